// File: rtl/tdm_mux_4x1.sv
// Four-channel time-division multiplexer with burst-limited round-robin arbitration
// into a single registered output slot with valid/ready flow control.
module tdm_mux_4x1 #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          in_valid,
    input  logic [4*DATA_W-1:0] in_data,
    output logic [3:0]          in_ready,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic [1:0]          out_sel,
    input  logic                out_ready
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);

    arb_state_t          state, state_next;
    logic [1:0]          c, c_next;
    logic [3:0]          cnt, cnt_next;
    logic                out_valid_next;
    logic [DATA_W-1:0]   out_data_next;
    logic [1:0]          out_sel_next;

    logic [DATA_W-1:0]   ch_data [4];
    logic                keep;
    logic                found;
    logic [1:0]          g;
    logic [1:0]          idx;
    logic                space;
    logic                load;

    for (genvar i = 0; i < 4; i++) begin : g_split
        assign ch_data[i] = in_data[i*DATA_W +: DATA_W];
    end

    // Stay on the current channel while its burst has budget left; otherwise
    // rotate starting just after it, so an exhausted channel ends up last.
    always_comb begin
        keep  = (state == BURST) && in_valid[c] && (cnt < BURST_MAX);
        found = 1'b0;
        g     = c;
        idx   = c;
        if (keep) begin
            found = 1'b1;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                idx = c + 2'(k);
                if (!found && in_valid[idx]) begin
                    found = 1'b1;
                    g     = idx;
                end
            end
        end
    end

    always_comb begin
        space    = !out_valid || out_ready;
        load     = found && space && rst_n;
        in_ready = '0;
        if (load) begin
            in_ready[g] = 1'b1;
        end
    end

    always_comb begin
        state_next     = state;
        c_next         = c;
        cnt_next       = cnt;
        out_valid_next = out_valid;
        out_data_next  = out_data;
        out_sel_next   = out_sel;
        if (load) begin
            out_valid_next = 1'b1;
            out_data_next  = ch_data[g];
            out_sel_next   = g;
            state_next     = BURST;
            if (keep) begin
                cnt_next = cnt + 4'd1;
            end else begin
                cnt_next = 4'd1;
                c_next   = g;
            end
        end else begin
            if (out_ready) begin
                out_valid_next = 1'b0;
            end
            if (state == BURST && space && !in_valid[c]) begin
                state_next = IDLE;
            end
        end
    end

    // c resets to 3 so the first search after reset starts at channel 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            c         <= 2'd3;
            cnt       <= 4'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 2'd0;
        end else begin
            state     <= state_next;
            c         <= c_next;
            cnt       <= cnt_next;
            out_valid <= out_valid_next;
            out_data  <= out_data_next;
            out_sel   <= out_sel_next;
        end
    end

endmodule

// File: tb/tb_tdm_mux_4x1.sv
// Directed self-checking bench for tdm_mux_4x1 (DATA_W=8, BURST_LEN=4).
module tb_tdm_mux_4x1;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_ready;

    int n_compared;
    int n_mismatched;

    logic [1:0]  full_seq [17];
    logic [7:0]  ch_val   [4];

    tdm_mux_4x1 #(.DATA_W(8), .BURST_LEN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("[TB] %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [3:0] valid, input logic [31:0] data, input logic ready);
        in_valid  = valid;
        in_data   = data;
        out_ready = ready;
    endtask

    task automatic check_beat(input string tag, input logic [1:0] sel, input logic [7:0] data);
        check_output({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_output({tag, "_sel"}, 32'(out_sel), 32'(sel));
        check_output({tag, "_data"}, 32'(out_data), 32'(data));
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        full_seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1,
                     2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
        ch_val   = '{8'h11, 8'h22, 8'h33, 8'h44};

        // Reset asserted before any clock edge, with every channel requesting.
        rst_n = 1'b1;
        apply_stimulus(4'hF, 32'h44332211, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_out_data", 32'(out_data), 32'h00);
        check_output("rst_out_sel", 32'(out_sel), 32'd0);
        check_output("rst_in_ready", 32'(in_ready), 32'h0);
        tick();
        tick();
        check_output("rst_hold_in_ready", 32'(in_ready), 32'h0);

        // Single requester on channel 2.
        apply_stimulus(4'b0100, 32'h00A50000, 1'b1);
        rst_n = 1'b1;
        #1;
        check_output("single_in_ready", 32'(in_ready), 32'b0100);
        tick();
        check_beat("single", 2'd2, 8'hA5);
        apply_stimulus(4'b0000, 32'h0, 1'b1);
        #1;
        check_output("idle_in_ready", 32'(in_ready), 32'h0);
        tick();
        check_output("drain_out_valid", 32'(out_valid), 32'd0);

        // Fresh reset, then all channels valid continuously.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        apply_stimulus(4'hF, 32'h44332211, 1'b1);
        for (int i = 0; i < 17; i++) begin
            tick();
            check_beat($sformatf("full_%0d", i), full_seq[i], ch_val[full_seq[i]]);
        end

        // Reset in the middle of channel 0's burst (cnt=2).
        tick();
        check_beat("pre_midrst", 2'd0, 8'h11);
        rst_n = 1'b0;
        #1;
        check_output("midrst_out_valid", 32'(out_valid), 32'd0);
        check_output("midrst_in_ready", 32'(in_ready), 32'h0);
        #1;
        rst_n = 1'b1;
        tick();
        check_beat("post_midrst", 2'd0, 8'h11);

        // Backpressure while holding a beat from channel 1.
        apply_stimulus(4'b0010, 32'h00003C00, 1'b1);
        tick();
        check_beat("bp_load", 2'd1, 8'h3C);
        apply_stimulus(4'b0010, 32'h00005A00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_output($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'h0);
            tick();
            check_beat($sformatf("bp_hold_%0d", i), 2'd1, 8'h3C);
        end
        out_ready = 1'b1;
        #1;
        check_output("bp_release_in_ready", 32'(in_ready), 32'b0010);
        tick();
        check_beat("bp_next", 2'd1, 8'h5A);

        // Go idle, then break channel 1's burst with channels 0 and 3 waiting.
        apply_stimulus(4'b0000, 32'h0, 1'b1);
        tick();
        check_output("bb_idle_valid", 32'(out_valid), 32'd0);
        apply_stimulus(4'b0010, 32'h40302010, 1'b1);
        tick();
        check_beat("bb_ch1_a", 2'd1, 8'h20);
        apply_stimulus(4'b1011, 32'h40302010, 1'b1);
        tick();
        check_beat("bb_ch1_b", 2'd1, 8'h20);
        apply_stimulus(4'b1001, 32'h40302010, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_beat($sformatf("bb_ch3_%0d", i), 2'd3, 8'h40);
        end
        tick();
        check_beat("bb_ch0", 2'd0, 8'h10);

        // Lone requester keeps being re-granted across burst boundaries.
        apply_stimulus(4'b0001, 32'h000000E7, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_beat($sformatf("solo_%0d", i), 2'd0, 8'hE7);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/tdm_mux_4x1.md
TDM_MUX_4X1 -- requirements
Module: tdm_mux_4x1

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the channel data width in bits.
REQ-002 The block SHALL have parameter BURST_LEN, default 4, giving the maximum consecutive beats granted to one channel (legal range 1..15).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 The block SHALL have these ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  4  per-channel data valid; bit i belongs to channel i.
- in_data  input  4*DATA_W  channel i data at bits [i*DATA_W +: DATA_W].
- in_ready  output  4  per-channel accept; a beat transfers on channel i when in_valid[i] and in_ready[i] are both high at a rising clk edge.
- out_valid  output  1  output register holds a beat.
- out_data  output  DATA_W  beat data.
- out_sel  output  2  source channel of the beat on out_data.
- out_ready  input  1  downstream accept.

Function
REQ-005 The block SHALL hold the following internal state: a one-entry output register; current channel c (2 bits); beat counter cnt (4 bits); and an arbiter state in {IDLE, BURST}.
REQ-006 The output register SHALL have space in a cycle when out_valid=0 or out_ready=1.
REQ-007 Grant g in BURST state SHALL be c when in_valid[c]=1 and cnt<BURST_LEN.
REQ-008 In all other cases, g SHALL be the first channel with in_valid set, searched in the order c+1, c+2, c+3, c (modulo 4).
REQ-009 When no in_valid bit is set, there SHALL be no grant.
REQ-010 in_ready[i] SHALL be 1 only when a grant exists, i==g, and the output register has space; all other bits SHALL be 0.
REQ-011 in_ready SHALL be combinational from in_valid, out_valid, out_ready, c, cnt and state.
REQ-012 On a load (a transfer on channel g), the block SHALL:
- set out_data to channel g's data;
- set out_sel to g;
- set out_valid to 1;
- set state to BURST.
REQ-013 On a load, the counters SHALL update as follows:
- if state=BURST, g==c and cnt<BURST_LEN: cnt SHALL increment;
- otherwise: cnt SHALL become 1 and c SHALL become g.
REQ-014 Latency SHALL be exactly one cycle from an input transfer to out_valid=1 carrying that beat.
- Throughput SHALL be one beat per cycle while out_ready=1.
REQ-015 When out_valid=1 and out_ready=1 with no load in the same cycle, out_valid SHALL become 0 on the next edge.
REQ-016 When out_valid=1 and out_ready=0, out_data and out_sel SHALL remain unchanged, and in_ready SHALL be 0000.
REQ-017 State BURST SHALL go to IDLE in any cycle where the output register has space and in_valid[c]=0.
- If another channel loads in that same cycle, REQ-012 and REQ-013 take precedence: state SHALL be BURST, c SHALL be g and cnt SHALL be 1.
REQ-018 When cnt reaches BURST_LEN, channel c SHALL have lowest priority for the next grant.
- If c is the only requester, c SHALL be re-granted with cnt=1.
REQ-019 With BURST_LEN=1 the block SHALL behave as a pure round-robin mux.
REQ-020 A channel dropping in_valid without a transfer SHALL lose nothing; only transferred beats appear at the output.
REQ-021 Beat order per channel SHALL be preserved, and no beat SHALL be duplicated or dropped.

Reset
REQ-022 While rst_n=0, the block SHALL immediately force these values, independent of clk:
- out_valid=0, out_data=0, out_sel=0;
- c=3, cnt=0, state=IDLE;
- in_ready=0000.
REQ-023 The first grant after reset release SHALL search in the order 0,1,2,3.
REQ-024 Reset asserted mid-burst SHALL discard the beat held in the output register.

Verification
REQ-025 Reset: rst_n=0 with all in_valid=1 -> out_valid=0, out_data=0x00, out_sel=0 and in_ready=0000, all without a clk edge.
REQ-026 Single channel: only in_valid[2]=1 with data 0xA5, out_ready=1 -> in_ready=0100 in the same cycle; next cycle out_valid=1, out_data=0xA5, out_sel=2.
REQ-027 Full load: all in_valid=1 continuously, out_ready=1, BURST_LEN=4 -> out_sel sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0, with no idle cycles.
REQ-028 Backpressure: out_valid=1 carrying 0x3C from channel 1, then out_ready=0 for 3 cycles -> out_data=0x3C and out_sel=1 held, in_ready=0000; first beat after out_ready=1 appears the following cycle.
REQ-029 Broken burst: channel 1 sends 2 beats then drops in_valid, while channels 0 and 3 are valid -> next grant is channel 3, then channel 0 after channel 3's burst.
REQ-030 Mid-burst reset: rst_n pulsed low while out_valid=1 and cnt=2 -> out_valid=0 at once; after release with all channels valid, first out_sel=0.
